// File: rtl/wb_pkg.sv
// Shared widths, queue entry type and source-select encoding for the writeback merge block.
// Forwarding users: see WB_MERGE_FWD_EN in writeback_merge.sv and wb_fifo.sv.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SelNone,
        SelMem,
        SelQueue,
        SelAlu
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// ALU-result queue with address-match invalidate; killed entries are squeezed out every cycle.
// Pending-write lookup is built only when WB_MERGE_FWD_EN is defined.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [REG_ADDR_W-1:0]   push_addr_i,
    input  logic [DATA_W-1:0]       push_data_i,
    input  logic                    pop_i,
    input  logic                    kill_i,
    input  logic [REG_ADDR_W-1:0]   kill_addr_i,
    input  logic [REG_ADDR_W-1:0]   fwd_addr_i,
    output wb_entry_t               head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    fwd_hit_o,
    output logic [DATA_W-1:0]       fwd_data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_idx, wr_idx;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
        end
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        wr_idx   = rd_ptr_d;
        rd_idx   = rd_ptr_q;
        count_d  = '0;
        // Survivors are repacked behind the new read pointer, so the head is always live.
        for (int k = 0; k < DEPTH; k++) begin
            rd_idx = rd_ptr_q + PTR_W'(k);
            if (mem_q[rd_idx].valid && !(pop_i && k == 0) &&
                !(kill_i && mem_q[rd_idx].addr == kill_addr_i)) begin
                mem_d[wr_idx] = mem_q[rd_idx];
                wr_idx        = wr_idx + PTR_W'(1);
                count_d       = count_d + CNT_W'(1);
            end
        end
        if (push_i) begin
            mem_d[wr_idx] = '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
            count_d       = count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

`ifdef WB_MERGE_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = rd_ptr_q;
        // Oldest to newest, so the youngest matching entry wins.
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PTR_W'(k);
            if (mem_q[fwd_idx].valid && mem_q[fwd_idx].addr == fwd_addr_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = mem_q[fwd_idx].data;
            end
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr_i;
    assign fwd_hit_o       = 1'b0;
    assign fwd_data_o      = '0;
`endif

endmodule

// File: rtl/writeback_merge.sv
// Merges queued ALU results and always-accepted load results onto one registered RF write port.
// Define WB_MERGE_FWD_EN to build the pending-write lookup; otherwise fwd_hit/fwd_data are 0.
module writeback_merge
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [REG_ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]       alu_data,
    output logic                    alu_ready,
    input  logic                    mem_valid,
    input  logic [REG_ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    enc,
    output logic [REG_ADDR_W-1:0]   addrc,
    output logic [DATA_W-1:0]       datac,
    input  logic [REG_ADDR_W-1:0]   fwd_addr,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t             head;
    logic [CNT_W-1:0]      q_count;
    logic                  q_fwd_hit;
    logic [DATA_W-1:0]     q_fwd_data;
    logic                  alu_accept, alu_kill, pop, push;
    wb_sel_e               sel;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic                  enc_q, enc_d;
    logic [REG_ADDR_W-1:0] addrc_q, addrc_d;
    logic [DATA_W-1:0]     datac_q, datac_d;

    // Ready looks only at stored occupancy, so a pop at full does not admit a push that cycle.
    assign alu_ready  = !reset && (q_count < CNT_W'(DEPTH));
    assign alu_accept = alu_valid && alu_ready;
    assign alu_kill   = mem_valid && (mem_addr == alu_addr);

    always_comb begin
        sel      = SelNone;
        sel_addr = '0;
        sel_data = '0;
        if (mem_valid) begin
            sel      = SelMem;
            sel_addr = mem_addr;
            sel_data = mem_data;
        end else if (head.valid) begin
            sel      = SelQueue;
            sel_addr = head.addr;
            sel_data = head.data;
        end else if (alu_accept) begin
            sel      = SelAlu;
            sel_addr = alu_addr;
            sel_data = alu_data;
        end
    end

    assign pop  = (sel == SelQueue);
    assign push = alu_accept && !alu_kill && (sel != SelAlu);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_addr_i (alu_addr),
        .push_data_i (alu_data),
        .pop_i       (pop),
        .kill_i      (mem_valid),
        .kill_addr_i (mem_addr),
        .fwd_addr_i  (fwd_addr),
        .head_o      (head),
        .count_o     (q_count),
        .fwd_hit_o   (q_fwd_hit),
        .fwd_data_o  (q_fwd_data)
    );

    // r0 writes are consumed but never strobed; the port keeps its last real write.
    always_comb begin
        enc_d   = (sel != SelNone) && (sel_addr != '0);
        addrc_d = enc_d ? sel_addr : addrc_q;
        datac_d = enc_d ? sel_data : datac_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enc_q   <= 1'b0;
            addrc_q <= '0;
            datac_q <= '0;
        end else begin
            enc_q   <= enc_d;
            addrc_q <= addrc_d;
            datac_q <= datac_d;
        end
    end

    assign enc   = enc_q && !reset;
    assign addrc = reset ? '0 : addrc_q;
    assign datac = reset ? '0 : datac_q;
    assign count = reset ? '0 : q_count;

`ifdef WB_MERGE_FWD_EN
    // Youngest source first: this cycle's load, this cycle's ALU, queue, last issued write.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_addr != '0) begin
            if (mem_valid && mem_addr == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data;
            end else if (alu_accept && alu_addr == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = alu_data;
            end else if (q_fwd_hit) begin
                fwd_hit  = 1'b1;
                fwd_data = q_fwd_data;
            end else if (enc_q && addrc_q == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = datac_q;
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr, q_fwd_hit, q_fwd_data};
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_writeback_merge.sv
// Directed bench for writeback_merge: expected RF writes are queued as stimulus is applied and
// matched in order by a monitor; forwarding expectations follow the WB_MERGE_FWD_EN build.
module tb_writeback_merge;

    localparam int unsigned DEPTH = 4;
`ifdef WB_MERGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, alu_ready, enc, fwd_hit;
    logic [4:0]  alu_addr, mem_addr, addrc, fwd_addr;
    logic [31:0] alu_data, mem_data, datac, fwd_data;
    logic [2:0]  count;

    exp_t sb [$];
    exp_t got, want;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    writeback_merge #(
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .enc       (enc),
        .addrc     (addrc),
        .datac     (datac),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad);
        mem_valid = mv;
        mem_addr  = ma;
        mem_data  = md;
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Every strobed write must be the next expected one.
    always @(posedge clock) begin
        #1;
        if (enc !== 1'b0) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $display("FAIL unexpected_write: observed addr %0d data 0x%0h expected none",
                         addrc, datac);
                $error("unexpected write addr %0d data 0x%0h", addrc, datac);
            end
            if (sb.size() != 0) begin
                want = sb.pop_front();
                got  = '{addr: addrc, data: datac};
                checks++;
                assert (got === want) else begin
                    errors++;
                    $display("FAIL write_order: observed %0d/0x%0h expected %0d/0x%0h",
                             got.addr, got.data, want.addr, want.data);
                    $error("write order observed %0d/0x%0h expected %0d/0x%0h",
                           got.addr, got.data, want.addr, want.data);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        fwd_addr = '0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) tick();
        #1;
        check("rst_alu_ready", alu_ready, 0);
        check("rst_count", count, 0);
        check("rst_enc", enc, 0);
        check("rst_addrc", addrc, 0);
        check("rst_datac", datac, 0);
        tick();
        reset = 1'b0;
        #1;
        check("ready_after_reset", alu_ready, 1);

        // Bypass into an empty queue
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h11);
        sb.push_back('{addr: 5'd3, data: 32'h11});
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("bypass_count", count, 0);

        // Load beats a same-cycle ALU result
        tick();
        drive(1'b1, 5'd5, 32'hB, 1'b1, 5'd4, 32'hA);
        sb.push_back('{addr: 5'd5, data: 32'hB});
        sb.push_back('{addr: 5'd4, data: 32'hA});
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("prio_count", count, 1);
        tick();
        #1;
        check("prio_drained", count, 0);

        // Load kills an older queued result to the same register
        tick();
        drive(1'b1, 5'd20, 32'h100, 1'b1, 5'd7, 32'h1);
        sb.push_back('{addr: 5'd20, data: 32'h100});
        tick();
        drive(1'b1, 5'd21, 32'h101, 1'b1, 5'd8, 32'h2);
        sb.push_back('{addr: 5'd21, data: 32'h101});
        tick();
        drive(1'b1, 5'd7, 32'h9, 1'b0, 5'd0, 32'h0);
        sb.push_back('{addr: 5'd7, data: 32'h9});
        sb.push_back('{addr: 5'd8, data: 32'h2});
        #1;
        check("kill_pre_count", count, 2);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("kill_count", count, 1);
        tick();
        #1;
        check("kill_drained", count, 0);

        // Same-cycle ALU offer to the load's register is dropped
        tick();
        drive(1'b1, 5'd12, 32'h33, 1'b1, 5'd12, 32'h44);
        sb.push_back('{addr: 5'd12, data: 32'h33});
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("drop_count", count, 0);

        // Fill under five cycles of load pressure, then drain
        for (int i = 0; i < 6; i++) begin
            int n;
            n = (i < 4) ? i : 4;
            tick();
            drive(i < 5, 5'(16 + i), 32'(32'h200 + i), 1'b1, 5'(24 + n), 32'(32'h300 + n));
            if (i < 5) begin
                sb.push_back('{addr: 5'(16 + i), data: 32'(32'h200 + i)});
            end
            #1;
            check($sformatf("full_ready_%0d", i), alu_ready, (i < 4) ? 1 : 0);
            if (i == 4) begin
                check("full_count", count, 4);
            end
            if (i == 5) begin
                for (int j = 0; j < 4; j++) begin
                    sb.push_back('{addr: 5'(24 + j), data: 32'(32'h300 + j)});
                end
            end
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd28, 32'h304);
        sb.push_back('{addr: 5'd28, data: 32'h304});
        #1;
        check("full_reaccept_ready", alu_ready, 1);
        check("full_reaccept_count", count, 3);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (6) tick();
        #1;
        check("full_drained", count, 0);

        // Writes to r0 are swallowed
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("zero_enc", enc, 0);
        check("zero_count", count, 0);

        // Forwarding from queue, same-cycle load and the issued write
        tick();
        drive(1'b1, 5'd22, 32'h77, 1'b1, 5'd9, 32'h5);
        sb.push_back('{addr: 5'd22, data: 32'h77});
        tick();
        drive(1'b1, 5'd23, 32'h78, 1'b0, 5'd0, 32'h0);
        sb.push_back('{addr: 5'd23, data: 32'h78});
        sb.push_back('{addr: 5'd9, data: 32'h5});
        fwd_addr = 5'd9;
        #1;
        check("fwd_q_hit", fwd_hit, FWD ? 1 : 0);
        check("fwd_q_data", fwd_data, FWD ? 32'h5 : 32'h0);
        fwd_addr = 5'd23;
        #1;
        check("fwd_mem_hit", fwd_hit, FWD ? 1 : 0);
        check("fwd_mem_data", fwd_data, FWD ? 32'h78 : 32'h0);
        fwd_addr = 5'd0;
        #1;
        check("fwd_zero_hit", fwd_hit, 0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        fwd_addr = 5'd9;
        #1;
        check("fwd_port_hit", fwd_hit, FWD ? 1 : 0);
        check("fwd_port_data", fwd_data, FWD ? 32'h5 : 32'h0);
        fwd_addr = 5'd0;

        // Reset with three results still queued
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b1, 5'(25 + i), 32'(32'h400 + i), 1'b1, 5'(10 + i), 32'(32'h500 + i));
            sb.push_back('{addr: 5'(25 + i), data: 32'(32'h400 + i)});
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("rst_mid_pre_count", count, 3);
        reset = 1'b1;
        #1;
        check("rst_mid_enc", enc, 0);
        check("rst_mid_count", count, 0);
        check("rst_mid_ready", alu_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_after_enc", enc, 0);
        check("rst_mid_after_ready", alu_ready, 1);
        repeat (5) tick();
        #1;
        check("rst_mid_final_count", count, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
